dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: fair round-robin on ties, one access per two cycles.
// Each transaction is IDLE/RESP -> ACCESS (grant, memory strobe) -> RESP (completion pulse).
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_rvalid0,
  output logic              o_rvalid1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                winner;

  // On a tie the port not granted last wins; a lone requester always wins.
  assign winner = (i_req0 & i_req1) ? ~last_q : i_req1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (i_req0 | i_req1) begin
          state_d = ACCESS;
          last_d  = winner;
          id_d    = winner;
          we_d    = winner ? i_we1    : i_we0;
          addr_d  = winner ? i_addr1  : i_addr0;
          wdata_d = winner ? i_wdata1 : i_wdata0;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = we_q ? '0 : i_mem_rdata;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode straight from registered state so reset clears them without waiting for a clock.
  assign o_gnt0      = (state_q == ACCESS) && !id_q;
  assign o_gnt1      = (state_q == ACCESS) &&  id_q;
  assign o_rvalid0   = (state_q == RESP)   && !id_q;
  assign o_rvalid1   = (state_q == RESP)   &&  id_q;
  assign o_rdata0    = o_rvalid0 ? rdata_q : '0;
  assign o_rdata1    = o_rvalid1 ? rdata_q : '0;
  assign o_mem_we    = (state_q == ACCESS) && we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level model of arbitration and memory.
module tb_dmem_arbiter;

  localparam int MAXC = 4096;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic        clk;
  logic        i_reset;
  logic        i_req0, i_req1, i_we0, i_we1;
  logic [31:0] i_addr0, i_addr1, i_wdata0, i_wdata1;
  logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_mem_we, o_busy;
  logic [31:0] o_rdata0, o_rdata1, o_mem_addr, o_mem_wdata, i_mem_rdata;

  logic [31:0] mem [64];
  logic        mem_clear;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
    .o_gnt0(o_gnt0), .o_gnt1(o_gnt1), .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
    .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_mem_rdata = mem[o_mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
    end else if (o_mem_we) begin
      mem[o_mem_addr[5:0]] <= o_mem_wdata;
    end
  end

  // Reference model state
  int          n_tests, n_fail;
  int          cyc, next_free, lg;
  bit   [1:0]  exp_gnt [MAXC];
  bit   [1:0]  exp_rv  [MAXC];
  bit          exp_we  [MAXC];
  logic [31:0] exp_rd  [MAXC];
  logic [31:0] m_addr, m_wdata;
  logic [31:0] ref_mem [64];

  // Requester state
  bit          pend   [2];
  bit          op_we  [2];
  logic [31:0] op_addr  [2];
  logic [31:0] op_wdata [2];
  int          prob   [2];
  op_t         q0[$], q1[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    logic [31:0] e0, e1;
    e0 = exp_rv[cyc][0] ? exp_rd[cyc] : 32'h0;
    e1 = exp_rv[cyc][1] ? exp_rd[cyc] : 32'h0;
    check_eq("gnt",    64'({o_gnt1, o_gnt0}),       64'(exp_gnt[cyc]));
    check_eq("rvalid", 64'({o_rvalid1, o_rvalid0}), 64'(exp_rv[cyc]));
    check_eq("rdata0", 64'(o_rdata0), 64'(e0));
    check_eq("rdata1", 64'(o_rdata1), 64'(e1));
    check_eq("mem_we", 64'(o_mem_we), 64'(exp_we[cyc]));
    check_eq("mem_addr",  64'(o_mem_addr),  64'(m_addr));
    check_eq("mem_wdata", 64'(o_mem_wdata), 64'(m_wdata));
    check_eq("busy", 64'(o_busy), 64'((exp_gnt[cyc] != 2'b00) || (exp_rv[cyc] != 2'b00)));
  endtask

  task automatic update_drivers();
    op_t o;
    for (int p = 0; p < 2; p++) begin
      if (pend[p] && exp_gnt[cyc][p]) pend[p] = 1'b0;
      if (!pend[p]) begin
        if (p == 0 && q0.size() > 0) begin
          o = q0.pop_front(); pend[p] = 1'b1;
          op_we[p] = o.we; op_addr[p] = o.addr; op_wdata[p] = o.wdata;
        end else if (p == 1 && q1.size() > 0) begin
          o = q1.pop_front(); pend[p] = 1'b1;
          op_we[p] = o.we; op_addr[p] = o.addr; op_wdata[p] = o.wdata;
        end else if (int'($urandom_range(99)) < prob[p]) begin
          pend[p]     = 1'b1;
          op_we[p]    = 1'($urandom_range(1));
          op_addr[p]  = $urandom_range(15);
          op_wdata[p] = $urandom;
        end
      end
    end
    i_req0 = pend[0]; i_we0 = op_we[0]; i_addr0 = op_addr[0]; i_wdata0 = op_wdata[0];
    i_req1 = pend[1]; i_we1 = op_we[1]; i_addr1 = op_addr[1]; i_wdata1 = op_wdata[1];
  endtask

  // Transaction view: a free arbiter accepts at this edge, grants next cycle, completes the one after.
  task automatic model_edge();
    int w;
    int idx;
    logic [31:0] rd;
    if (cyc >= next_free && (pend[0] || pend[1])) begin
      w  = (pend[0] && pend[1]) ? 1 - lg : (pend[1] ? 1 : 0);
      lg = w;
      exp_gnt[cyc+1] = 2'b01 << w;
      exp_we[cyc+1]  = op_we[w];
      m_addr  = op_addr[w];
      m_wdata = op_wdata[w];
      idx = int'(op_addr[w][5:0]);
      rd  = op_we[w] ? 32'h0 : ref_mem[idx];
      if (op_we[w]) ref_mem[idx] = op_wdata[w];
      exp_rv[cyc+2] = 2'b01 << w;
      exp_rd[cyc+2] = rd;
      next_free = cyc + 2;
    end
  endtask

  task automatic finish_tick();
    update_drivers();
    model_edge();
    @(posedge clk);
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    finish_tick();
  endtask

  task automatic drain();
    prob[0] = 0; prob[1] = 0;
    repeat (6) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_gnt"},    64'({o_gnt1, o_gnt0}), 64'(0));
    check_eq({tag, "_rvalid"}, 64'({o_rvalid1, o_rvalid0}), 64'(0));
    check_eq({tag, "_rdata"},  64'({o_rdata1, o_rdata0}), 64'(0));
    check_eq({tag, "_mem_we"}, 64'(o_mem_we), 64'(0));
    check_eq({tag, "_addr"},   64'(o_mem_addr), 64'(0));
    check_eq({tag, "_wdata"},  64'(o_mem_wdata), 64'(0));
    check_eq({tag, "_busy"},   64'(o_busy), 64'(0));
  endtask

  task automatic reset_mid_access();
    logic [31:0] old;
    bit found;
    drain();
    old = ref_mem[48];
    q1.push_back('{we: 1'b1, addr: 32'h30, wdata: 32'hCAFE0030});
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      check_cycle();
      if (exp_gnt[cyc][1]) found = 1'b1;
      else finish_tick();
    end
    check_eq("rst_access_reached", 64'(found), 64'(1));
    i_reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_all_zero("rst_held");
    check_eq("rst_mem_0x30", 64'(mem[48]), 64'(old));
    ref_mem[48] = old;
    cyc++;
    for (int c = cyc; c < cyc + 4; c++) begin
      exp_gnt[c] = '0; exp_rv[c] = '0; exp_we[c] = 1'b0; exp_rd[c] = '0;
    end
    pend[0] = 1'b0; pend[1] = 1'b0;
    lg = 1; next_free = 0; m_addr = '0; m_wdata = '0;
    i_reset = 1'b0;
    finish_tick();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0; next_free = 0; lg = 1;
    m_addr = '0; m_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h01010101 ^ 32'h5A5A0000;
    pend[0] = 1'b0; pend[1] = 1'b0;
    op_we[0] = 1'b0; op_we[1] = 1'b0;
    op_addr[0] = '0; op_addr[1] = '0; op_wdata[0] = '0; op_wdata[1] = '0;
    prob[0] = 0; prob[1] = 0;
    i_req0 = 1'b0; i_req1 = 1'b0; i_we0 = 1'b0; i_we1 = 1'b0;
    i_addr0 = '0; i_addr1 = '0; i_wdata0 = '0; i_wdata1 = '0;
    i_reset = 1'b1; mem_clear = 1'b1;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0; mem_clear = 1'b0;
    finish_tick();

    // Both ports saturating from reset: alternation starting with port 0.
    prob[0] = 100; prob[1] = 100;
    repeat (20) tick();
    drain();

    // Port 0 write then read-back of 0x10.
    q0.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hDEADBEEF});
    q0.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
    repeat (8) tick();
    drain();

    // Port 1 alone reads 0x20.
    q1.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
    repeat (4) tick();
    drain();

    // Port 0 alone keeps requesting through its own RESP cycles.
    prob[0] = 100;
    repeat (10) tick();
    drain();

    prob[0] = 50; prob[1] = 50;
    repeat (1500) tick();

    reset_mid_access();

    prob[0] = 70; prob[1] = 40;
    repeat (300) tick();
    drain();

    @(negedge clk);
    for (int i = 0; i < 64; i++) check_eq("final_mem", 64'(mem[i]), 64'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
